// File: rtl/jk_drv_pkg.sv
// Shared types and constants for the JK excitation driver.
package jk_drv_pkg;

  // Driver FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    DRIVE = 2'd2,
    FLUSH = 2'd3
  } state_t;

  // Excitation tables indexed by {cur, nxt}; each entry is {j, k}.
  // Don't-care positions are filled with 0.
  localparam logic [1:0] EXC_FILL0 [4] = '{2'b00, 2'b10, 2'b01, 2'b00};
  // Don't-care positions are filled with 1.
  localparam logic [1:0] EXC_FILL1 [4] = '{2'b01, 2'b11, 2'b11, 2'b10};

  // Width needed to hold a count from 0 to width inclusive
  function automatic int unsigned lw_of(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/jk_exc_driver_lut.sv
// Combinational JK excitation lookup: (cur, nxt) -> (j, k).
module jk_exc_lut
  import jk_drv_pkg::*;
#(
  parameter int unsigned DC_FILL = 0
) (
  input  logic cur,
  input  logic nxt,
  output logic j_c,
  output logic k_c
);

  logic [1:0] sel;
  logic [1:0] jk;

  // Pick the table for the selected don't-care fill and look up the transition
  always_comb begin
    sel = {cur, nxt};
    jk  = 2'b00;
    if (DC_FILL == 0) begin
      jk = EXC_FILL0[sel];
    end else begin
      jk = EXC_FILL1[sel];
    end
  end

  assign j_c = jk[1];
  assign k_c = jk[0];

endmodule

// File: rtl/jk_exc_driver.sv
// Drives J/K of a downstream JK flip-flop so its q follows a loaded serial
// pattern, and checks the fed-back q two cycles after each bit is issued.
module jk_exc_driver
  import jk_drv_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DC_FILL = 0,
  parameter int unsigned LW      = lw_of(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LW-1:0]    load_len,
  input  logic             abort,
  output logic             j,
  output logic             k,
  input  logic             q_fb,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [LW-1:0]    err_cnt,
  output logic [LW-1:0]    first_err_idx
);

  state_t           state;
  logic [WIDTH-1:0] pat;
  logic [LW-1:0]    len_r;
  logic [LW-1:0]    idx;
  logic             pred_q;
  logic             flush_cnt;

  // Two-stage check pipeline: issue -> flip-flop update -> compare
  logic             s1_vld;
  logic             s1_exp;
  logic [LW-1:0]    s1_idx;
  logic             s2_vld;
  logic             s2_exp;
  logic [LW-1:0]    s2_idx;

  logic             lut_cur_c;
  logic             j_c;
  logic             k_c;
  logic [LW-1:0]    len_clamp_c;
  logic             last_c;

  // Clamp the requested length to the pattern width
  always_comb begin
    len_clamp_c = load_len;
    if (load_len > LW'(WIDTH)) begin
      len_clamp_c = LW'(WIDTH);
    end
  end

  // First bit starts from the real q; later bits from the predicted q
  always_comb begin
    lut_cur_c = pred_q;
    if (state == SYNC) begin
      lut_cur_c = q_fb;
    end
  end

  // The bit being issued this cycle is the last one of the pattern
  always_comb begin
    last_c = (idx == (len_r - LW'(1)));
  end

  jk_exc_lut #(
    .DC_FILL (DC_FILL)
  ) u_lut (
    .cur (lut_cur_c),
    .nxt (pat[0]),
    .j_c (j_c),
    .k_c (k_c)
  );

  // Control FSM, J/K drive, check pipeline and error bookkeeping
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      load_ready    <= 1'b1;
      busy          <= 1'b0;
      j             <= 1'b0;
      k             <= 1'b0;
      done          <= 1'b0;
      mismatch      <= 1'b0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      pat           <= '0;
      len_r         <= '0;
      idx           <= '0;
      pred_q        <= 1'b0;
      flush_cnt     <= 1'b0;
      s1_vld        <= 1'b0;
      s1_exp        <= 1'b0;
      s1_idx        <= '0;
      s2_vld        <= 1'b0;
      s2_exp        <= 1'b0;
      s2_idx        <= '0;
    end else if (abort && (state != IDLE)) begin
      // Cancel: release the flip-flop, drop in-flight checks, keep the error tally
      state      <= IDLE;
      load_ready <= 1'b1;
      busy       <= 1'b0;
      j          <= 1'b0;
      k          <= 1'b0;
      done       <= 1'b0;
      s1_vld     <= 1'b0;
      s2_vld     <= 1'b0;
    end else begin
      done   <= 1'b0;
      s1_vld <= 1'b0;
      s2_vld <= s1_vld;
      s2_exp <= s1_exp;
      s2_idx <= s1_idx;

      if (s2_vld && (q_fb != s2_exp)) begin
        mismatch <= 1'b1;
        if (err_cnt != {LW{1'b1}}) begin
          err_cnt <= err_cnt + LW'(1);
        end
        if (!mismatch) begin
          first_err_idx <= s2_idx;
        end
      end

      case (state)
        IDLE: begin
          j <= 1'b0;
          k <= 1'b0;
          if (load_valid) begin
            mismatch      <= 1'b0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            pat           <= load_data;
            len_r         <= len_clamp_c;
            idx           <= '0;
            if (len_clamp_c == '0) begin
              done <= 1'b1;
            end else begin
              state      <= SYNC;
              load_ready <= 1'b0;
              busy       <= 1'b1;
            end
          end
        end

        SYNC, DRIVE: begin
          j      <= j_c;
          k      <= k_c;
          pred_q <= pat[0];
          pat    <= pat >> 1;
          s1_vld <= 1'b1;
          s1_exp <= pat[0];
          s1_idx <= idx;
          idx    <= idx + LW'(1);
          if (last_c) begin
            state     <= FLUSH;
            flush_cnt <= 1'b0;
          end else begin
            state <= DRIVE;
          end
        end

        FLUSH: begin
          j <= 1'b0;
          k <= 1'b0;
          if (flush_cnt) begin
            state      <= IDLE;
            load_ready <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b1;
          end else begin
            flush_cnt <= 1'b1;
          end
        end

        default: begin
          state      <= IDLE;
          load_ready <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
